// File: rtl/bcd_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_event_counter
// Purpose  : Multi-digit BCD up/down event counter. Counts rising edges on
//            inc_event / dec_event, with wrap or saturate behaviour at the
//            ends of the range, all-9s / all-0s status flags and a one-cycle
//            wrap pulse aligned with the wrapped value on digits.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_event_counter #(
  parameter int DIGITS   = 2,     // number of BCD digits, 1..8
  parameter bit SATURATE = 1'b0   // 0 = wrap at the ends, 1 = clamp
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  inc_event,
  input  logic                  dec_event,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  wrap_pulse
);

  localparam int c_W = 4 * DIGITS;

  logic [c_W-1:0]    r_digits;
  logic              r_inc_prev;
  logic              r_dec_prev;
  logic              r_wrap;

  logic [DIGITS-1:0] w_is9;
  logic [DIGITS-1:0] w_is0;
  logic [c_W-1:0]    w_inc_digits;
  logic [c_W-1:0]    w_dec_digits;
  logic              w_inc_rise;
  logic              w_dec_rise;
  logic              w_all9;
  logic              w_all0;

  assign w_inc_rise = inc_event & ~r_inc_prev;
  assign w_dec_rise = dec_event & ~r_dec_prev;

  // Per-digit BCD cells. The carry (borrow) into digit i is simply "every
  // lower digit is 9 (0)", so each cell is a prefix-AND rather than a chain.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_d;
      logic       w_cin;
      logic       w_bin;

      assign w_d       = r_digits[4*gi +: 4];
      assign w_is9[gi] = (w_d == 4'd9);
      assign w_is0[gi] = (w_d == 4'd0);

      if (gi == 0) begin : g_ones
        assign w_cin = 1'b1;
        assign w_bin = 1'b1;
      end else begin : g_upper
        assign w_cin = &w_is9[gi-1:0];
        assign w_bin = &w_is0[gi-1:0];
      end

      assign w_inc_digits[4*gi +: 4] = !w_cin        ? w_d  :
                                       w_is9[gi]     ? 4'd0 : (w_d + 4'd1);
      assign w_dec_digits[4*gi +: 4] = !w_bin        ? w_d  :
                                       w_is0[gi]     ? 4'd9 : (w_d - 4'd1);
    end
  endgenerate

  // A carry/borrow out of the top digit happens exactly when all digits are
  // at the end of the range; the wrapped value then falls out of the cells.
  assign w_all9 = &w_is9;
  assign w_all0 = &w_is0;

  // Edge-detect history, count update and registered wrap pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_digits   <= '0;
      r_inc_prev <= 1'b0;
      r_dec_prev <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_inc_prev <= inc_event;
      r_dec_prev <= dec_event;
      r_wrap     <= 1'b0;
      if (clear) begin
        r_digits <= '0;
      end else if (w_inc_rise && w_dec_rise) begin
        r_digits <= r_digits;
      end else if (w_inc_rise) begin
        if (!(w_all9 && SATURATE)) begin
          r_digits <= w_inc_digits;
        end
        r_wrap <= w_all9 && !SATURATE;
      end else if (w_dec_rise) begin
        if (!(w_all0 && SATURATE)) begin
          r_digits <= w_dec_digits;
        end
        r_wrap <= w_all0 && !SATURATE;
      end
    end
  end

  assign digits     = r_digits;
  assign at_max     = w_all9;
  assign at_zero    = w_all0;
  assign wrap_pulse = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_event_counter
// Purpose  : Self-checking bench for bcd_event_counter. Three instances share
//            one stimulus stream: 2-digit wrap, 2-digit saturate, 4-digit
//            wrap. A decimal reference model pushes expected values into a
//            scoreboard when stimulus is driven; they are popped and compared
//            after the clock edge, alongside directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_event_counter;

  logic        Clk = 1'b0;
  logic        Reset, inc_event, dec_event, clear;
  logic [7:0]  d_w, d_s;
  logic [15:0] d_x;
  logic        mx_w, z_w, wp_w;
  logic        mx_s, z_s, wp_s;
  logic        mx_x, z_x, wp_x;

  always #5 Clk = ~Clk;

  bcd_event_counter #(.DIGITS(2), .SATURATE(1'b0)) u_wrap (
    .Clk(Clk), .Reset(Reset), .inc_event(inc_event), .dec_event(dec_event),
    .clear(clear), .digits(d_w), .at_max(mx_w), .at_zero(z_w), .wrap_pulse(wp_w));

  bcd_event_counter #(.DIGITS(2), .SATURATE(1'b1)) u_sat (
    .Clk(Clk), .Reset(Reset), .inc_event(inc_event), .dec_event(dec_event),
    .clear(clear), .digits(d_s), .at_max(mx_s), .at_zero(z_s), .wrap_pulse(wp_s));

  bcd_event_counter #(.DIGITS(4), .SATURATE(1'b0)) u_wide (
    .Clk(Clk), .Reset(Reset), .inc_event(inc_event), .dec_event(dec_event),
    .clear(clear), .digits(d_x), .at_max(mx_x), .at_zero(z_x), .wrap_pulse(wp_x));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one slot per instance.
  int m_cnt [3];
  bit m_pi  [3];
  bit m_pd  [3];
  bit m_wr  [3];
  int m_max [3] = '{99, 99, 9999};
  bit m_sat [3] = '{1'b0, 1'b1, 1'b0};

  // Scoreboard: three entries (one per instance) per driven cycle.
  int q_cnt [$];
  bit q_wr  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int          t;
    b = '0;
    t = v;
    for (int k = 0; k < 4; k++) begin
      b[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic model(input bit r, input bit i, input bit d, input bit c);
    bit ir, dr;
    for (int n = 0; n < 3; n++) begin
      if (r) begin
        m_cnt[n] = 0; m_pi[n] = 0; m_pd[n] = 0; m_wr[n] = 0;
      end else begin
        ir = i & ~m_pi[n];
        dr = d & ~m_pd[n];
        m_pi[n] = i;
        m_pd[n] = d;
        m_wr[n] = 0;
        if (c) m_cnt[n] = 0;
        else if (ir && dr) m_cnt[n] = m_cnt[n];
        else if (ir) begin
          if (m_cnt[n] == m_max[n]) begin
            if (!m_sat[n]) begin m_cnt[n] = 0; m_wr[n] = 1; end
          end else m_cnt[n]++;
        end else if (dr) begin
          if (m_cnt[n] == 0) begin
            if (!m_sat[n]) begin m_cnt[n] = m_max[n]; m_wr[n] = 1; end
          end else m_cnt[n]--;
        end
      end
      q_cnt.push_back(m_cnt[n]);
      q_wr.push_back(m_wr[n]);
    end
  endtask

  task automatic compare_outputs();
    int  ec;
    bit  ew;
    logic [15:0] od;
    logic om, oz, ow;
    for (int n = 0; n < 3; n++) begin
      ec = q_cnt.pop_front();
      ew = q_wr.pop_front();
      case (n)
        0:       begin od = {8'h00, d_w}; om = mx_w; oz = z_w; ow = wp_w; end
        1:       begin od = {8'h00, d_s}; om = mx_s; oz = z_s; ow = wp_s; end
        default: begin od = d_x;          om = mx_x; oz = z_x; ow = wp_x; end
      endcase
      check($sformatf("sb_digits%0d", n), 32'(od), 32'(to_bcd(ec)));
      check($sformatf("sb_max%0d", n),    32'(om), 32'(ec == m_max[n]));
      check($sformatf("sb_zero%0d", n),   32'(oz), 32'(ec == 0));
      check($sformatf("sb_wrap%0d", n),   32'(ow), 32'(ew));
    end
  endtask

  // Drive one cycle of inputs, predict, let the edge happen, then compare.
  task automatic step(input bit r, input bit i, input bit d, input bit c);
    Reset = r; inc_event = i; dec_event = d; clear = c;
    model(r, i, d, c);
    @(posedge Clk);
    #1;
    compare_outputs();
  endtask

  task automatic inc_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic dec_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    Reset = 1'b1; inc_event = 1'b0; dec_event = 1'b0; clear = 1'b0;
    #1;

    // Reset sequencing
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_digits", 32'(d_w), 32'h00);
    check("rst_zero",   32'(z_w), 32'd1);
    check("rst_max",    32'(mx_w), 32'd0);
    check("rst_wrap",   32'(wp_w), 32'd0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("held_thru_reset", 32'(d_w), 32'h01);
    repeat (10) step(0, 1, 0, 0);
    check("held_counts_once", 32'(d_w), 32'h01);
    step(0, 0, 0, 0);

    // BCD carry: nine more pulses reach 10, then to 99
    inc_pulses(9);
    check("carry_to_10", 32'(d_w), 32'h10);
    inc_pulses(89);
    check("reach_99", 32'(d_w), 32'h99);
    check("reach_99_max", 32'(mx_w), 32'd1);

    // Wrap mode up and down; saturate instance clamps
    step(0, 1, 0, 0);
    check("wrap_up_digits", 32'(d_w), 32'h00);
    check("wrap_up_pulse",  32'(wp_w), 32'd1);
    check("wrap_up_zero",   32'(z_w), 32'd1);
    check("sat_up_clamp",   32'(d_s), 32'h99);
    step(0, 0, 0, 0);
    check("wrap_pulse_one_cycle", 32'(wp_w), 32'd0);
    step(0, 0, 1, 0);
    check("wrap_dn_digits", 32'(d_w), 32'h99);
    check("wrap_dn_pulse",  32'(wp_w), 32'd1);
    step(0, 0, 0, 0);

    // Saturate at both ends
    step(1, 0, 0, 0);
    inc_pulses(99);
    inc_pulses(3);
    check("sat_hold_99", 32'(d_s), 32'h99);
    check("sat_no_wrap", 32'(wp_s), 32'd0);
    step(1, 0, 0, 0);
    dec_pulses(3);
    check("sat_hold_00", 32'(d_s), 32'h00);
    check("wrap_dn_97",  32'(d_w), 32'h97);

    // Simultaneous edges and clear
    step(1, 0, 0, 0);
    inc_pulses(42);
    step(0, 1, 1, 0);
    check("both_edges_hold", 32'(d_w), 32'h42);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    check("clear_wins", 32'(d_w), 32'h00);
    step(0, 1, 0, 0);
    check("no_edge_after_clear", 32'(d_w), 32'h00);
    step(0, 0, 0, 0);

    // Width scaling: ripple through three digits
    step(1, 0, 0, 0);
    inc_pulses(999);
    check("wide_0999", 32'(d_x), 32'h0999);
    inc_pulses(1);
    check("wide_1000", 32'(d_x), 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_event_counter.md
# bcd_event_counter

Parametrised multi-digit BCD event counter for on-screen game statistics such as deaths, kills and lives. It counts rising edges on an increment input and an optional decrement input, so a level-held event counts exactly once. It supports wrap or saturate mode and drives BCD digits straight into the score and HUD digit renderers. Status flags and a one-cycle rollover pulse feed the game-state controller.

## Interface
- DIGITS, 2: number of BCD digits, range 1..8.
- SATURATE, 0: 0 = wrap at the top and bottom of the range; 1 = clamp at all-9s and at zero.
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high; sampled on the rising edge of Clk.
- inc_event  input  1  level event; each 0->1 transition adds 1.
- dec_event  input  1  level event; each 0->1 transition subtracts 1.
- clear  input  1  synchronous clear of the count to zero (level, not edge).
- digits  output  4*DIGITS  packed BCD; digits[3:0] = ones, digits[7:4] = tens, and so on.
- at_max  output  1  high while every digit is 9.
- at_zero  output  1  high while every digit is 0.
- wrap_pulse  output  1  one-cycle pulse when the count wraps (wrap mode only).

## Operation
- Edge detection:
  - One registered previous-sample bit per event input: inc_prev, dec_prev. Both reset to 0.
  - inc_rise = inc_event & ~inc_prev; dec_rise = dec_event & ~dec_prev.
  - Both prev bits update every cycle, including cycles where clear is high.
  - An input already high when Reset releases counts once on the first non-reset edge.
  - A high level held any number of cycles counts once. A new count needs the input low for at least one sampled cycle.
- Priority at each edge, highest first:
  1. Reset: all digits to 0, prev bits to 0, wrap_pulse to 0.
  2. clear: all digits to 0; wrap_pulse 0.
  3. inc_rise and dec_rise together: no change; wrap_pulse 0.
  4. inc_rise alone: increment.
  5. dec_rise alone: decrement.
  6. Otherwise: hold.
- Increment (per-digit BCD ripple):
  - Ones digit +1. A digit at 9 becomes 0 and carries into the next digit.
  - No digit value above 9 is ever stored.
  - Top carry-out with SATURATE=0: result is all zeros, wrap_pulse=1 next cycle.
  - Top carry-out with SATURATE=1: the count stays at all-9s, wrap_pulse stays 0.
- Decrement:
  - Ones digit -1. A digit at 0 becomes 9 and borrows from the next digit.
  - Top borrow-out with SATURATE=0: result is all-9s, wrap_pulse=1.
  - Top borrow-out with SATURATE=1: the count stays at zero.
- at_max and at_zero are combinational decodes of the digit registers; they are not registered.
- wrap_pulse is registered. It is high exactly during the cycle after the wrapping edge, which is the same cycle the wrapped value appears on digits.

## Timing
- Reset values: digits = 0, at_zero = 1, at_max = 0, wrap_pulse = 0, inc_prev = dec_prev = 0.
- Latency:
  - An event input that rises before edge k updates digits at edge k, visible during cycle k+1. That is one cycle from the input change to the output.
  - clear takes effect at the first edge it is sampled high.
- Throughput: at most one count per two cycles per input, because an edge needs low-then-high samples.
- Reset mid-count: the count is lost, and the edge state is cleared at the same edge.
- The digit update path is a ripple over DIGITS BCD cells. DIGITS=8 must meet the 50 MHz system clock.

## Test plan
- Reset sequencing:
  - Stimulus: Reset for 2 cycles, all inputs 0.
  - Required: digits=0, at_zero=1, at_max=0, wrap_pulse=0.
  - Stimulus: then hold inc_event high through the Reset release.
  - Required: digits=01 after the first non-reset edge, and still 01 after 10 more cycles with inc_event held high.
- BCD carry (DIGITS=2):
  - Stimulus: apply 10 separated inc pulses, each high 1 cycle then low 1 cycle.
  - Required: digits goes 01..09, then 10 (0x10, never 0x0A).
  - Stimulus: 89 more pulses.
  - Required: digits=99, at_max=1.
- Wrap mode (SATURATE=0):
  - Stimulus: from 99, one inc pulse.
  - Required: digits=00, wrap_pulse=1 for exactly one cycle, at_zero=1.
  - Stimulus: then one dec pulse.
  - Required: digits=99, wrap_pulse=1 for one cycle.
- Saturate mode (SATURATE=1):
  - Stimulus: from 99, 3 inc pulses.
  - Required: digits stays 99, wrap_pulse never asserts.
  - Stimulus: from 00, 3 dec pulses.
  - Required: digits stays 00.
- Simultaneous events and clear:
  - Stimulus: at 42, inc_event and dec_event rise on the same cycle.
  - Required: digits stays 42.
  - Stimulus: clear and inc_rise on the same cycle.
  - Required: digits=00.
  - Stimulus: with inc_event still held high, drop clear.
  - Required: digits stays 00, because there is no new edge.
- Width scaling:
  - Stimulus: DIGITS=4, preload to 0999 via 999 pulses, then 1 inc pulse.
  - Required: digits=1000, with the carry rippling correctly through three digits.
